// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit multi-cycle CPU:
// opcodes, instruction fields and sequencer states.
package cpu_pkg;

  localparam int NUM_REGS = 4;
  localparam int REG_AW   = $clog2(NUM_REGS);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_NOT  = 3'b010;
  localparam logic [2:0] OP_LDI  = 3'b011;
  localparam logic [2:0] OP_JZ   = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b101;
  localparam logic [2:0] OP_OUT  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam int OP_HI = 7;
  localparam int OP_LO = 5;
  localparam int RD_HI = 4;
  localparam int RD_LO = 3;
  localparam int RS_HI = 2;
  localparam int RS_LO = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_FETCH_IMM,
    S_EXEC,
    S_HALT
  } state_t;

  function automatic logic needs_imm(input logic [2:0] op);
    return (op == OP_LDI) || (op == OP_JZ) || (op == OP_JMP);
  endfunction

  function automatic logic is_alu(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 4-entry register file: two async read ports,
// one synchronous write port, async active-low clear.
module cpu_regfile
  import cpu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] rb,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [WIDTH-1:0]  wdata
);

  logic [WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[wa] <= wdata;
    end
  end

  assign rdata_a = regs[ra];
  assign rdata_b = regs[rb];

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle fetch/execute sequencer driving an
// external combinational ALU over a req/valid fetch port.
module cpu_control
  import cpu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_valid,
  input  logic [7:0]            mem_rdata,
  output logic [2:0]            alu_opcode,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  input  logic [WIDTH-1:0]      alu_res,
  input  logic                  alu_zero,
  input  logic                  alu_ovf,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic                  flag_zero,
  output logic                  flag_ovf,
  output logic                  halted
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [7:0]            ir;

  logic [2:0]        op;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs;

  logic              rf_we;
  logic [WIDTH-1:0]  rf_wdata;
  logic [REG_AW-1:0] rf_ra;
  logic [WIDTH-1:0]  rdata_a;
  logic [WIDTH-1:0]  rdata_b;

  logic [ADDR_WIDTH-1:0] imm_addr;
  logic                  in_exec;

  assign op = ir[OP_HI:OP_LO];
  assign rd = ir[RD_HI:RD_LO];
  assign rs = ir[RS_HI:RS_LO];

  // Fetch port follows state directly so reset drops it at once.
  assign mem_req  = (state == S_FETCH) || (state == S_FETCH_IMM);
  assign mem_addr = pc;
  assign halted   = (state == S_HALT);

  assign in_exec  = (state == S_EXEC);
  assign imm_addr = ADDR_WIDTH'(mem_rdata);

  // NOT reads its single source through port a.
  assign rf_ra = (op == OP_NOT) ? rs : rd;

  cpu_regfile #(
    .WIDTH(WIDTH)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra      (rf_ra),
    .rb      (rs),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .we      (rf_we),
    .wa      (rd),
    .wdata   (rf_wdata)
  );

  always_comb begin
    alu_opcode = OP_HALT;
    alu_a      = '0;
    alu_b      = '0;
    if (in_exec) begin
      alu_opcode = op;
      alu_a      = rdata_a;
      alu_b      = rdata_b;
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = alu_res;
    unique case (1'b1)
      in_exec && is_alu(op): rf_we = 1'b1;
      (state == S_FETCH_IMM) && mem_valid && (op == OP_LDI): begin
        rf_we    = 1'b1;
        rf_wdata = WIDTH'(mem_rdata);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      ir        <= '0;
      flag_zero <= 1'b0;
      flag_ovf  <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (mem_valid) begin
            ir    <= mem_rdata;
            pc    <= pc + ADDR_WIDTH'(1);
            state <= needs_imm(mem_rdata[OP_HI:OP_LO])
                     ? S_FETCH_IMM : S_EXEC;
          end
        end
        S_FETCH_IMM: begin
          if (mem_valid) begin
            state <= S_FETCH;
            unique case (1'b1)
              op == OP_JMP:              pc <= imm_addr;
              (op == OP_JZ) && flag_zero: pc <= imm_addr;
              default:                   pc <= pc + ADDR_WIDTH'(1);
            endcase
          end
        end
        S_EXEC: begin
          if (is_alu(op)) begin
            flag_zero <= alu_zero;
            flag_ovf  <= alu_ovf;
          end
          if (op == OP_OUT) begin
            out_data  <= rdata_b;
            out_valid <= 1'b1;
          end
          state <= (op == OP_HALT) ? S_HALT : S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control: program memory with
// configurable wait states and a reference ALU model.
module tb_cpu_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_valid = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic [2:0] alu_opcode;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_res;
  logic       alu_zero;
  logic       alu_ovf;
  logic [7:0] out_data;
  logic       out_valid;
  logic       flag_zero;
  logic       flag_ovf;
  logic       halted;

  int total = 0;
  int bad = 0;

  logic [7:0] mem [256];
  int         wait_n = 0;
  int         wcnt = 0;
  logic       toggle_mode = 1'b0;
  logic       prev_req = 1'b0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_addr = 8'h00;
  int         stab_err = 0;

  logic [7:0] acc [$];
  logic [7:0] outs [$];
  logic       oz [$];
  logic       oo [$];

  cpu_control #(
    .WIDTH(8),
    .ADDR_WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_valid  (mem_valid),
    .mem_rdata  (mem_rdata),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_res    (alu_res),
    .alu_zero   (alu_zero),
    .alu_ovf    (alu_ovf),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .flag_zero  (flag_zero),
    .flag_ovf   (flag_ovf),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_res = 8'h00;
    alu_ovf = 1'b0;
    case (alu_opcode)
      3'b000: begin
        alu_res = alu_a + alu_b;
        alu_ovf = (alu_a[7] == alu_b[7]) && (alu_res[7] != alu_a[7]);
      end
      3'b001: alu_res = alu_a & alu_b;
      3'b010: alu_res = ~alu_a;
      default: alu_res = 8'h00;
    endcase
    alu_zero = (alu_res == 8'h00);
  end

  // Memory responder plus address-stability monitor.
  always @(negedge clk) begin
    if (rst_n && mem_req && prev_req && !prev_valid
        && mem_addr !== prev_addr)
      stab_err++;
    if (toggle_mode) begin
      mem_valid = ~mem_valid;
      mem_rdata = 8'hE0;
    end else if (rst_n && mem_req) begin
      if (wcnt >= wait_n) begin
        mem_valid = 1'b1;
        mem_rdata = mem[mem_addr];
        acc.push_back(mem_addr);
        wcnt = 0;
      end else begin
        mem_valid = 1'b0;
        wcnt++;
      end
    end else begin
      mem_valid = 1'b0;
      wcnt = 0;
    end
    prev_req   = rst_n && mem_req;
    prev_valid = mem_valid;
    prev_addr  = mem_addr;
  end

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      outs.push_back(out_data);
      oz.push_back(flag_zero);
      oo.push_back(flag_ovf);
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
  endtask

  task automatic load_prog_a();
    clear_mem();
    mem[0] = 8'h68; mem[1] = 8'h7F;
    mem[2] = 8'h70; mem[3] = 8'h01;
    mem[4] = 8'h0C; mem[5] = 8'hC2;
    mem[6] = 8'hE0;
  endtask

  task automatic do_reset(input int w);
    @(negedge clk);
    rst_n = 1'b0;
    wait_n = w;
    toggle_mode = 1'b0;
    repeat (2) @(negedge clk);
    acc.delete();
    outs.delete();
    oz.delete();
    oo.delete();
    stab_err = 0;
    rst_n = 1'b1;
  endtask

  task automatic run_to_halt(input int budget, output int cycles);
    cycles = 0;
    while (!halted && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    load_prog_a();
    @(negedge clk);
    rst_n = 1'b0;
    wait_n = 0;
    #1;
    total++;
    if ({mem_req, mem_addr, out_valid, out_data, flag_zero,
         flag_ovf, halted, alu_a, alu_b} !== 36'h0) begin
      bad++;
      $display("FAIL reset_outs got req=%0b addr=%h ov=%0b od=%h z=%0b o=%0b h=%0b a=%h b=%h want all 0",
               mem_req, mem_addr, out_valid, out_data, flag_zero,
               flag_ovf, halted, alu_a, alu_b);
    end
    total++;
    if (alu_opcode !== 3'b111) begin
      bad++;
      $display("FAIL reset_aluop got %b want 111", alu_opcode);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b0) begin
      bad++;
      $display("FAIL idle_req got %b want 0", mem_req);
    end
    @(posedge clk);
    #1;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
      bad++;
      $display("FAIL first_fetch got req=%b addr=%h want 1/00", mem_req, mem_addr);
    end
  endtask

  task automatic test_add_ovf();
    int cyc;
    load_prog_a();
    do_reset(0);
    run_to_halt(200, cyc);
    total++;
    if (halted !== 1'b1 || cyc != 11) begin
      bad++;
      $display("FAIL add_cycles got halted=%b cycles=%0d want 1/11", halted, cyc);
    end
    total++;
    if (outs.size() != 1) begin
      bad++;
      $display("FAIL add_pulses got %0d want 1", outs.size());
    end else begin
      total++;
      if (outs[0] !== 8'h80 || oo[0] !== 1'b1 || oz[0] !== 1'b0) begin
        bad++;
        $display("FAIL add_out got data=%h ovf=%b zero=%b want 80/1/0", outs[0], oo[0], oz[0]);
      end
    end
    total++;
    if (mem_addr !== 8'h07) begin
      bad++;
      $display("FAIL add_pc got %h want 07", mem_addr);
    end
  endtask

  task automatic test_halt_hold();
    toggle_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (mem_req !== 1'b0 || halted !== 1'b1 || mem_addr !== 8'h07) begin
        bad++;
        $display("FAIL halt_hold cyc %0d got req=%b halted=%b addr=%h want 0/1/07",
                 i, mem_req, halted, mem_addr);
      end
    end
    toggle_mode = 1'b0;
  endtask

  task automatic test_jz_taken();
    int cyc;
    logic ok;
    logic [7:0] e [10] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                           8'h05, 8'h06, 8'h07, 8'h20, 8'h21};
    clear_mem();
    mem[0] = 8'h60; mem[1] = 8'h00;
    mem[2] = 8'h58; mem[3] = 8'hC6;
    mem[4] = 8'h38; mem[5] = 8'hC6;
    mem[6] = 8'h80; mem[7] = 8'h20;
    mem[8] = 8'hE0;
    mem[8'h20] = 8'hC6; mem[8'h21] = 8'hE0;
    do_reset(0);
    run_to_halt(200, cyc);
    total++;
    if (outs.size() != 3) begin
      bad++;
      $display("FAIL jz_pulses got %0d want 3", outs.size());
    end else begin
      total++;
      if (outs[0] !== 8'hFF || oz[0] !== 1'b0) begin
        bad++;
        $display("FAIL not_res got %h z=%b want FF/0", outs[0], oz[0]);
      end
      total++;
      if (outs[1] !== 8'h00 || oz[1] !== 1'b1 || outs[2] !== 8'h00) begin
        bad++;
        $display("FAIL and_res got %h z=%b last=%h want 00/1/00", outs[1], oz[1], outs[2]);
      end
    end
    ok = (acc.size() == 10);
    for (int i = 0; i < 10; i++)
      if (ok && acc[i] !== e[i]) ok = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL jz_taken_seq got %0d fetches last=%h want 10 ending 20,21",
               acc.size(), acc.size() > 0 ? acc[acc.size()-1] : 8'hxx);
    end
    total++;
    if (flag_zero !== 1'b1 || mem_addr !== 8'h22) begin
      bad++;
      $display("FAIL jz_taken_end got z=%b addr=%h want 1/22", flag_zero, mem_addr);
    end
  endtask

  task automatic test_jz_fall();
    int cyc;
    logic ok;
    logic [7:0] e [10] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                           8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    clear_mem();
    mem[0] = 8'h60; mem[1] = 8'h0F;
    mem[2] = 8'h78; mem[3] = 8'h3C;
    mem[4] = 8'h38; mem[5] = 8'hC6;
    mem[6] = 8'h80; mem[7] = 8'h20;
    mem[8] = 8'hC0; mem[9] = 8'hE0;
    do_reset(0);
    run_to_halt(200, cyc);
    total++;
    if (outs.size() != 2) begin
      bad++;
      $display("FAIL jzf_pulses got %0d want 2", outs.size());
    end else begin
      total++;
      if (outs[0] !== 8'h0C || oz[0] !== 1'b0 || outs[1] !== 8'h0F) begin
        bad++;
        $display("FAIL jzf_outs got %h z=%b %h want 0C/0/0F", outs[0], oz[0], outs[1]);
      end
    end
    ok = (acc.size() == 10);
    for (int i = 0; i < 10; i++)
      if (ok && acc[i] !== e[i]) ok = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL jz_fall_seq got %0d fetches want 00..09", acc.size());
    end
  endtask

  task automatic test_wait_states();
    int cyc;
    logic ok;
    load_prog_a();
    do_reset(3);
    run_to_halt(400, cyc);
    total++;
    if (halted !== 1'b1 || cyc != 32) begin
      bad++;
      $display("FAIL wait_cycles got halted=%b cycles=%0d want 1/32", halted, cyc);
    end
    total++;
    if (outs.size() != 1 || outs[0] !== 8'h80 || oo[0] !== 1'b1) begin
      bad++;
      $display("FAIL wait_out got %0d pulses want 1 pulse of 80 with ovf", outs.size());
    end
    total++;
    if (stab_err != 0) begin
      bad++;
      $display("FAIL wait_stable got %0d addr changes want 0", stab_err);
    end
    ok = (acc.size() == 7);
    for (int i = 0; i < 7; i++)
      if (ok && acc[i] !== 8'(i)) ok = 1'b0;
    total++;
    if (!ok || mem_addr !== 8'h07) begin
      bad++;
      $display("FAIL wait_seq got %0d fetches pc=%h want 7/07", acc.size(), mem_addr);
    end
  endtask

  task automatic test_jmp_wrap();
    int cyc;
    logic ok;
    logic [7:0] e [5] = '{8'h00, 8'h01, 8'hFF, 8'h00, 8'h01};
    clear_mem();
    mem[0] = 8'hA0; mem[1] = 8'hFF;
    mem[8'hFF] = 8'h68;
    do_reset(0);
    run_to_halt(100, cyc);
    ok = (acc.size() == 5);
    for (int i = 0; i < 5; i++)
      if (ok && acc[i] !== e[i]) ok = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL jmp_wrap_seq got %0d fetches want 00,01,FF,00,01", acc.size());
    end
    total++;
    if (halted !== 1'b1 || cyc != 7 || mem_addr !== 8'h02) begin
      bad++;
      $display("FAIL jmp_wrap_end got h=%b cyc=%0d pc=%h want 1/7/02", halted, cyc, mem_addr);
    end
  endtask

  task automatic test_reset_mid_fetch();
    load_prog_a();
    do_reset(0);
    repeat (3) @(posedge clk);
    #1;
    wait_n = 50;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h02) begin
      bad++;
      $display("FAIL mid_pre got req=%b addr=%h want 1/02", mem_req, mem_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (mem_req !== 1'b0 || mem_addr !== 8'h00) begin
      bad++;
      $display("FAIL mid_async got req=%b addr=%h want 0/00", mem_req, mem_addr);
    end
    @(negedge clk);
    wait_n = 0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
      bad++;
      $display("FAIL mid_release got req=%b addr=%h want 1/00", mem_req, mem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_halt_hold();
    test_jz_taken();
    test_jz_fall();
    test_wait_states();
    test_jmp_wrap();
    test_reset_mid_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_control.md
Name: cpu_control

Overview:
Multi-cycle fetch/execute sequencer for the 8-bit CPU. It sits on the master side of the ALU interface and drives opcode and operands into the separately instantiated combinational ALU. It consumes the result and the zero/overflow outputs, owns the PC, the instruction register, a 4x8 register file and the flag register. Instructions and immediates are fetched over a simple req/valid memory handshake.

Parameters:
WIDTH, 8, data/register width; must match the ALU's WIDTH
ADDR_WIDTH, 8, program-counter and memory address width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
mem_req  output  1  fetch request; held until accepted
mem_addr  output  ADDR_WIDTH  fetch address (PC)
mem_valid  input  1  memory has data for the current request
mem_rdata  input  8  instruction/immediate byte
alu_opcode  output  3  to the ALU opcode input
alu_a  output  WIDTH  to the ALU operand a
alu_b  output  WIDTH  to the ALU operand b
alu_res  input  WIDTH  ALU result
alu_zero  input  1  ALU zero flag
alu_ovf  input  1  ALU overflow flag
out_data  output  WIDTH  OUT instruction data
out_valid  output  1  one-cycle strobe qualifying out_data
flag_zero  output  1  registered zero flag
flag_ovf  output  1  registered overflow flag
halted  output  1  high once HALT has executed

Behaviour:
- Instruction byte: [7:5] op, [4:3] rd, [2:1] rs, [0] reserved (ignored).
- Opcodes:
  - 000 ADD: rd = rd + rs.
  - 001 AND: rd = rd & rs.
  - 010 NOT: rd = ~rs.
  - 011 LDI: rd = next byte.
  - 100 JZ: if flag_zero, PC = next byte, else skip that byte.
  - 101 JMP: PC = next byte.
  - 110 OUT: emit rs.
  - 111 HALT.
- Reset (async, rst_n low): state IDLE, PC=0, IR=0, all registers=0, flags=0, mem_req=0, mem_addr=0, out_valid=0, out_data=0, halted=0. Reset mid-handshake drops mem_req immediately, and any in-flight mem_valid is discarded.
- States:
  - IDLE → FETCH unconditionally (1 cycle).
  - FETCH: mem_req=1, mem_addr=PC. On an edge with mem_valid=1: IR ← mem_rdata, PC ← PC+1, then go to EXEC for ops 000/001/010/110/111, or to FETCH_IMM for 011/100/101.
  - FETCH_IMM: mem_req=1, mem_addr=PC. On an edge with mem_valid=1:
    - LDI writes rd and sets PC+1.
    - JMP sets PC ← mem_rdata.
    - JZ sets PC ← mem_rdata if flag_zero, else PC+1.
    - Next state is FETCH.
  - EXEC (1 cycle):
    - ALU ops write alu_res to rd and load flag_zero ← alu_zero, flag_ovf ← alu_ovf.
    - OUT registers out_data ← reg[rs] and pulses out_valid for exactly one cycle.
    - HALT goes to HALT; all others go to FETCH.
  - HALT: terminal until reset. mem_req=0, halted=1.
- Handshake: mem_addr is stable while mem_req=1 and not accepted. mem_valid is ignored when mem_req=0. Any number of wait cycles is allowed, and the PC advances exactly once per accepted byte. Zero-wait memory gives 2 cycles per ALU/OUT instruction and 2 cycles per LDI/JZ/JMP.
- ALU drive: in EXEC, alu_opcode=IR[7:5], alu_a=reg[rd], alu_b=reg[rs]. For NOT, alu_a=reg[rs] instead. Outside EXEC, alu_opcode=3'b111, alu_a=0, alu_b=0.
- Flags change only on ALU ops; LDI, jumps and OUT leave them unchanged.
- rd==rs is legal: ADD doubles, AND is identity, NOT inverts in place.
- PC and immediate fetch wrap modulo 2^ADDR_WIDTH (0xFF+1 → 0x00).

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams OP_ADD..OP_HALT (ALU codes 000-010 identical to the ALU's);
  - FSM state encoding (IDLE, FETCH, FETCH_IMM, EXEC, HALT);
  - instruction field bit positions;
  - NUM_REGS=4.
- One sub-module: cpu_regfile, 4 x WIDTH, two async read ports, one synchronous write port, async active-low clear.

Test Plan:
- Reset then release, zero-wait memory → mem_req=0 in cycle 1, mem_req=1 with mem_addr=0x00 in cycle 2; all outputs 0 while rst_n=0.
- LDI r1,0x7F; LDI r2,0x01; ADD r1,r2; OUT r1 → one out_valid pulse with out_data=0x80, flag_ovf=1, flag_zero=0.
- LDI r0,0x00; NOT r3,r0; AND r3,r0; JZ 0x20 → r3 becomes 0xFF then 0x00, flag_zero=1, next fetch mem_addr=0x20. Repeat with a nonzero AND result → JZ falls through to PC+2.
- mem_valid delayed 3 cycles on every fetch → mem_addr and mem_req held stable, no PC double-increment, identical architectural results to the zero-wait run.
- JMP 0xFF where 0xFF holds LDI r1 → immediate fetched from 0x00, next opcode fetched from 0x01.
- HALT → halted=1, mem_req stays 0 despite mem_valid toggling. Separately, asserting rst_n=0 mid-FETCH with mem_req=1 → mem_req=0 without waiting for a clock edge, and PC=0 after release.
